// File: rtl/countdown_timer_if.sv
// Load handshake bundle for countdown_timer.
// The master proposes a start value and a mode; the slave accepts it when load_ready is high.
interface countdown_timer_if #(
    parameter int WIDTH = 5
);
    logic             load_valid;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic             load_ready;

    modport master (
        output load_valid,
        output load_value,
        output auto_reload,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        input  auto_reload,
        output load_ready
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter that pulses 'expired' for one cycle on terminal count.
// Supports one-shot or periodic (auto-reload) operation, pause (HOLD) and synchronous abort.
// Optional macro TIMER_PRESCALE_EN: when defined, a phase counter divides the clock so the
// count decrements once every PRESCALE cycles; when undefined, it decrements every cycle.
module countdown_timer #(
    parameter int WIDTH    = 5,
    parameter int PRESCALE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    countdown_timer_if.slave   ld,
    input  logic               pause,
    input  logic               abort,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               expired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_n;
    logic             mode;
    logic             mode_n;
    logic             expired_n;
    logic             tick;

    if (PRESCALE < 2 || PRESCALE > 256) begin : g_prescale_range
        $error("countdown_timer: PRESCALE must be within 2..256");
    end

    assign ld.load_ready = (state == IDLE);

`ifdef TIMER_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_n;

    // A tick is due on the last phase of each prescale period.
    always_comb begin
        tick = (phase == PW'(PRESCALE - 1));
    end

    // Phase advances only on edges where the counter actually runs; idle and abort clear it.
    always_comb begin
        phase_n = phase;
        if (state == IDLE || abort) begin
            phase_n = '0;
        end else if (!pause) begin
            phase_n = tick ? '0 : phase + PW'(1);
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else begin
            phase <= phase_n;
        end
    end
`else
    // Without the prescaler every running cycle is a tick.
    always_comb begin
        tick = 1'b1;
    end
`endif

    // Next-state and next-output logic: abort beats pause, pause beats the tick.
    always_comb begin
        state_n   = state;
        count_n   = count;
        reload_n  = reload;
        mode_n    = mode;
        expired_n = 1'b0;
        case (state)
            IDLE: begin
                if (ld.load_valid) begin
                    count_n  = ld.load_value;
                    reload_n = ld.load_value;
                    mode_n   = ld.auto_reload;
                    if (ld.load_value != '0) begin
                        state_n = RUN;
                    end else begin
                        expired_n = 1'b1;
                    end
                end
            end
            RUN, HOLD: begin
                if (abort) begin
                    count_n = '0;
                    state_n = IDLE;
                end else if (pause) begin
                    state_n = HOLD;
                end else begin
                    state_n = RUN;
                    if (tick) begin
                        if (count > WIDTH'(1)) begin
                            count_n = count - WIDTH'(1);
                        end else begin
                            expired_n = 1'b1;
                            if (mode) begin
                                count_n = reload;
                            end else begin
                                count_n = '0;
                                state_n = IDLE;
                            end
                        end
                    end
                end
            end
            default: begin
                count_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; busy is derived from the next state so it lines up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            reload  <= '0;
            mode    <= 1'b0;
            expired <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            reload  <= reload_n;
            mode    <= mode_n;
            expired <= expired_n;
            busy    <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with hand-computed expectations.
// When TIMER_PRESCALE_EN is defined the prescaled timing scenarios run instead of the
// per-cycle ones.
module tb_countdown_timer;

    localparam int WIDTH    = 5;
    localparam int PRESCALE = 4;
`ifdef TIMER_PRESCALE_EN
    localparam int MIDCOUNT = 10;
`else
    localparam int MIDCOUNT = 7;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             expired;

    int checks = 0;
    int errors = 0;

    countdown_timer_if #(.WIDTH(WIDTH)) ld_if ();

    countdown_timer #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (ld_if),
        .pause   (pause),
        .abort   (abort),
        .count   (count),
        .busy    (busy),
        .expired (expired)
    );

    // Free-running clock, rising edge at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input int expCount, input int expBusy,
                              input int expExpired, input int expReady);
        checkOutput({tag, ".count"},   int'(count),             expCount);
        checkOutput({tag, ".busy"},    int'(busy),              expBusy);
        checkOutput({tag, ".expired"}, int'(expired),           expExpired);
        checkOutput({tag, ".ready"},   int'(ld_if.load_ready),  expReady);
    endtask

    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] value,
                                 input logic ar, input logic p, input logic ab);
        ld_if.load_valid  = valid;
        ld_if.load_value  = value;
        ld_if.auto_reload = ar;
        pause             = p;
        abort             = ab;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic loadTimer(input logic [WIDTH-1:0] value, input logic ar);
        applyStimulus(1'b1, value, ar, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        checkState("reset", 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of a count acts immediately
        loadTimer(5'd10, 1'b0);
        checkState("mid.load", 10, 1, 0, 0);
        repeat (3) stepCycle();
        checkOutput("mid.before", int'(count), MIDCOUNT);
        rst_n = 1'b0;
        #1;
        checkState("mid.async", 0, 0, 0, 1);
        #2 rst_n = 1'b1;
        stepCycle();
        checkState("mid.after", 0, 0, 0, 1);

`ifdef TIMER_PRESCALE_EN
        // Load 2: count changes every 4 cycles, expired 8 cycles after load
        loadTimer(5'd2, 1'b0);
        checkState("pre.load", 2, 1, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            stepCycle();
            checkState($sformatf("pre.c%0d", i), (i < 4) ? 2 : ((i < 8) ? 1 : 0),
                       (i < 8) ? 1 : 0, (i == 8) ? 1 : 0, (i < 8) ? 0 : 1);
        end

        // Pausing for 3 cycles delays the expiry by exactly 3 cycles
        loadTimer(5'd2, 1'b0);
        repeat (2) stepCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            stepCycle();
            checkState($sformatf("prep.hold%0d", i), 2, 1, 0, 0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 6; j++) begin
            stepCycle();
            checkState($sformatf("prep.run%0d", j), ((2 + j) < 4) ? 2 : (((2 + j) < 8) ? 1 : 0),
                       (j < 6) ? 1 : 0, (j == 6) ? 1 : 0, (j < 6) ? 0 : 1);
        end
`else
        // One-shot load 5: 5,4,3,2,1,0 with a single expired pulse at 0
        loadTimer(5'd5, 1'b0);
        checkState("one.load", 5, 1, 0, 0);
        for (int k = 4; k >= 0; k--) begin
            stepCycle();
            checkState($sformatf("one.c%0d", k), k, (k > 0) ? 1 : 0,
                       (k == 0) ? 1 : 0, (k == 0) ? 1 : 0);
        end
        stepCycle();
        checkState("one.after", 0, 0, 0, 1);

        // Periodic load 3: 2,1,3 repeating, expired every third cycle
        loadTimer(5'd3, 1'b1);
        checkState("per.load", 3, 1, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            stepCycle();
            checkState($sformatf("per.c%0d", i), (i % 3 == 0) ? 3 : 3 - (i % 3), 1,
                       (i % 3 == 0) ? 1 : 0, 0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkState("per.abort", 0, 0, 0, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Pause at 5 for 4 cycles, resume, then abort+pause at 2
        loadTimer(5'd8, 1'b0);
        repeat (3) stepCycle();
        checkState("pa.c5", 5, 1, 0, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            stepCycle();
            checkState($sformatf("pa.hold%0d", i), 5, 1, 0, 0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkState("pa.c4", 4, 1, 0, 0);
        stepCycle();
        checkState("pa.c3", 3, 1, 0, 0);
        stepCycle();
        checkState("pa.c2", 2, 1, 0, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        stepCycle();
        checkState("pa.abort", 0, 0, 0, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkState("pa.idle", 0, 0, 0, 1);

        // Pause beats terminal count; abort beats terminal count with no pulse
        loadTimer(5'd2, 1'b0);
        stepCycle();
        checkState("term.c1", 1, 1, 0, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        stepCycle();
        checkState("term.pause", 1, 1, 0, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkState("term.abort", 0, 0, 0, 1);

        // Abort while idle does nothing
        stepCycle();
        checkState("idle.abort", 0, 0, 0, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Zero load: immediate pulse, stays idle even with auto_reload
        loadTimer(5'd0, 1'b1);
        checkState("zero.load", 0, 0, 1, 1);
        stepCycle();
        checkState("zero.after", 0, 0, 0, 1);

        // Back-pressure: a second load while busy is ignored
        loadTimer(5'd4, 1'b0);
        checkState("bp.load", 4, 1, 0, 0);
        applyStimulus(1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        stepCycle();
        checkState("bp.c3", 3, 1, 0, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkState("bp.c2", 2, 1, 0, 0);
        stepCycle();
        checkState("bp.c1", 1, 1, 0, 0);
        stepCycle();
        checkState("bp.c0", 0, 0, 1, 1);

        // Periodic with N=1: expired every cycle
        loadTimer(5'd1, 1'b1);
        checkState("n1.load", 1, 1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            stepCycle();
            checkState($sformatf("n1.c%0d", i), 1, 1, 1, 0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkState("n1.abort", 0, 0, 0, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counting timer; the counting-down counterpart of the team's free-running up-counters.
- Accepts a start value through a valid/ready load handshake, then decrements once per tick.
- Signals expiry with a one-cycle pulse, with optional automatic reload.
- Used by benches and control logic to generate timeouts and periodic events on the shared clock.

Parameters:
- WIDTH, 5, bit width of the load value and count.
- PRESCALE, 4, clock cycles per tick; used only when TIMER_PRESCALE_EN is defined; legal range 2..256.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  start request.
- load_value  input  WIDTH  start count.
- load_ready  output  1  high when a load can be accepted; equals (state==IDLE).
- auto_reload  input  1  sampled at load acceptance; 1 = periodic mode.
- pause  input  1  level; freezes counting while high.
- abort  input  1  synchronous stop.
- count  output  WIDTH  current remaining count, registered.
- busy  output  1  high in RUN or HOLD.
- expired  output  1  one-cycle pulse on terminal count.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, count=0, expired=0, busy=0, load_ready=1. The internal reload register and mode bit clear to 0.
- States: IDLE, RUN, HOLD. Registered outputs: count, expired, busy.
- IDLE + (load_valid && load_ready):
  - count <= load_value; reload register <= load_value; mode <= auto_reload.
  - If load_value != 0, next state is RUN.
  - If load_value == 0, count=0, expired=1 on the same edge, and the state stays IDLE. A zero load is always one-shot.
- load_valid while not in IDLE: ignored (load_ready=0); no queuing.
- RUN, per tick (every cycle unless the prescaler is enabled):
  - count > 1: count <= count-1.
  - count == 1, one-shot: count <= 0, expired <= 1, next state IDLE.
  - count == 1, periodic: count <= reload value, expired <= 1, stay in RUN.
- Latency: load of N ≥ 1 at edge t0 gives expired high in the cycle after edge t0+N.
  - Periodic mode: expired pulses every N ticks.
  - Minimum period N=1 gives expired high continuously, one pulse per cycle.
- expired is high for exactly one cycle per terminal event; it is 0 in all other cycles.
- pause=1 in RUN: next state HOLD, count frozen. HOLD with pause=0: return to RUN.
  - A tick never occurs on the same edge that enters HOLD.
  - The prescaler phase is also frozen in HOLD.
- abort=1 in RUN or HOLD: count <= 0, state IDLE, no expired pulse. abort has priority over pause and over terminal count on the same edge. abort in IDLE has no effect.
- Simultaneous pause and terminal count: pause wins; count stays 1.
- Arithmetic: unsigned. Decrement below 0 is impossible by construction; no wrap-around is permitted.
- load_value and auto_reload are don't-care unless a load is accepted.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - A ceil(log2(PRESCALE))-bit phase counter, cleared on load acceptance, abort and reset, advances in RUN only.
  - A tick occurs when phase == PRESCALE-1, and the phase then wraps to 0.
  - Load-to-expired latency becomes N*PRESCALE cycles.
- Not defined: tick every cycle in RUN; PRESCALE is ignored; no phase register exists.

Test Plan:
- Reset mid-count: load 10, assert rst_n=0 after 3 cycles -> count=0, busy=0, expired=0, load_ready=1 immediately; after release, count stays 0 and load_ready=1.
- One-shot: load 5, auto_reload=0 -> count 5,4,3,2,1,0 on consecutive edges; expired high exactly once, coincident with count=0; load_ready returns to 1.
- Periodic: load 3, auto_reload=1, run 12 cycles -> count sequence 3,2,1,3,2,1,...; expired pulses at cycles 3,6,9,12; busy stays 1.
- Pause/abort: load 8, pause for 4 cycles at count=5 -> count holds 5 for 4 cycles, then resumes 4,3. Assert abort together with pause at count=2 -> count=0, IDLE, no expired.
- Zero and back-pressure: load 0 -> expired pulse on the load edge, state stays IDLE. Load 4, then load_valid with value 9 while busy -> ignored; expired after 4 cycles.
- TIMER_PRESCALE_EN with PRESCALE=4: load 2 -> count changes every 4 cycles; expired 8 cycles after load. Pause for 3 cycles -> expiry delayed exactly 3 cycles.
